// File: rtl/rename_free_list_pkg.sv
// Shared processor constants and register-index types for the rename stage.
package rename_free_list_pkg;

  localparam int unsigned SUPER_SCALAR_WIDTH = 2;
  localparam int unsigned NUM_ARCH_REGS      = 64;
  localparam int unsigned NUM_PHYS_REGS      = 128;
  localparam int unsigned FREE_DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS;

  localparam int unsigned PREG_W = $clog2(NUM_PHYS_REGS);
  localparam int unsigned AREG_W = 6;
  localparam int unsigned IDX_W  = $clog2(FREE_DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(SUPER_SCALAR_WIDTH) + 1;

  typedef logic [PREG_W-1:0] phys_reg_t;
  typedef logic [AREG_W-1:0] arch_reg_t;

endpackage

// File: rtl/rename_free_list_slot_compactor.sv
// Per-slot prefix offsets and total popcount of a bundle-wide valid mask.
module slot_compactor
  import rename_free_list_pkg::*;
(
  input  logic [SUPER_SCALAR_WIDTH-1:0]            mask,
  output logic [SUPER_SCALAR_WIDTH-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]                         total
);

  // Running sum: slot i's offset counts the valid slots below it.
  always_comb begin
    total  = '0;
    offset = '0;
    for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
      offset[i] = total;
      total     = total + CNT_W'(mask[i]);
    end
  end

endmodule

// File: rtl/rename_free_list.sv
// Circular free list of physical registers with head/tail/committed-head pointers.
module rename_free_list
  import rename_free_list_pkg::*;
(
  input  logic                                      clk_in,
  input  logic                                      rst_n_in,
  input  logic                                      alloc_valid_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0]             alloc_request_in,
  output logic                                      alloc_ready_out,
  output logic [SUPER_SCALAR_WIDTH-1:0][PREG_W-1:0] alloc_preg_out,
  input  logic [SUPER_SCALAR_WIDTH-1:0]             free_valid_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0][PREG_W-1:0] free_preg_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0]             retire_valid_in,
  input  logic                                      flush_in,
  output logic [PTR_W-1:0]                          free_count_out
);

  logic [PTR_W-1:0] head_q, tail_q, chead_q;
  logic [PTR_W-1:0] head_d, tail_d, chead_d;
  phys_reg_t        free_q [FREE_DEPTH];

  logic [SUPER_SCALAR_WIDTH-1:0][CNT_W-1:0] alloc_off, free_off, retire_off;
  logic [CNT_W-1:0]                         alloc_cnt, free_cnt, retire_cnt;
  logic                                     alloc_fire;

  slot_compactor u_alloc_cmp (
    .mask   (alloc_request_in),
    .offset (alloc_off),
    .total  (alloc_cnt)
  );

  slot_compactor u_free_cmp (
    .mask   (free_valid_in),
    .offset (free_off),
    .total  (free_cnt)
  );

  slot_compactor u_retire_cmp (
    .mask   (retire_valid_in),
    .offset (retire_off),
    .total  (retire_cnt)
  );

  // Readiness and read-out use the pre-update pointers only.
  always_comb begin
    free_count_out  = tail_q - head_q;
    alloc_ready_out = !flush_in && (free_count_out >= PTR_W'(alloc_cnt));
    alloc_fire      = alloc_valid_in && alloc_ready_out;
    for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
      alloc_preg_out[i] = free_q[IDX_W'(head_q + PTR_W'(alloc_off[i]))];
    end
  end

  // Flush rewinds head to the committed point, including this cycle's retires.
  always_comb begin
    chead_d = chead_q + PTR_W'(retire_cnt);
    tail_d  = tail_q + PTR_W'(free_cnt);
    head_d  = head_q;
    if (flush_in) begin
      head_d = chead_d;
    end else if (alloc_fire) begin
      head_d = head_q + PTR_W'(alloc_cnt);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= PTR_W'(FREE_DEPTH);
      for (int i = 0; i < FREE_DEPTH; i++) begin
        free_q[i] <= PREG_W'(NUM_ARCH_REGS + i);
      end
    end else begin
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
        if (free_valid_in[i]) begin
          free_q[IDX_W'(tail_q + PTR_W'(free_off[i]))] <= free_preg_in[i];
        end
      end
    end
  end

  // Freed registers may never spill onto uncommitted allocations.
  ap_no_free_overflow: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    PTR_W'(tail_d - chead_d) <= PTR_W'(FREE_DEPTH))
    else $fatal(1, "free list overflow");

  ap_commit_behind_head: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    PTR_W'(head_d - chead_d) <= PTR_W'(tail_d - chead_d))
    else $error("committed head passed allocation head");

endmodule

// File: tb/tb_rename_free_list.sv
// Directed bench for rename_free_list with a queue-based free-list model.
module tb_rename_free_list;
  import rename_free_list_pkg::*;

  localparam int unsigned W = SUPER_SCALAR_WIDTH;

  logic                     clk_in = 1'b0;
  logic                     rst_n_in = 1'b0;
  logic                     alloc_valid_in = 1'b0;
  logic [W-1:0]             alloc_request_in = '0;
  logic                     alloc_ready_out;
  logic [W-1:0][PREG_W-1:0] alloc_preg_out;
  logic [W-1:0]             free_valid_in = '0;
  logic [W-1:0][PREG_W-1:0] free_preg_in = '0;
  logic [W-1:0]             retire_valid_in = '0;
  logic                     flush_in = 1'b0;
  logic [PTR_W-1:0]         free_count_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  rename_free_list dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .alloc_valid_in   (alloc_valid_in),
    .alloc_request_in (alloc_request_in),
    .alloc_ready_out  (alloc_ready_out),
    .alloc_preg_out   (alloc_preg_out),
    .free_valid_in    (free_valid_in),
    .free_preg_in     (free_preg_in),
    .retire_valid_in  (retire_valid_in),
    .flush_in         (flush_in),
    .free_count_out   (free_count_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: available registers in hand-out order, plus allocated-but-uncommitted ones.
  phys_reg_t m_free[$];
  phys_reg_t m_spec[$];

  function automatic void model_reset();
    m_free.delete();
    m_spec.delete();
    for (int i = 0; i < FREE_DEPTH; i++) m_free.push_back(PREG_W'(NUM_ARCH_REGS + i));
  endfunction

  always @(posedge clk_in) begin
    int need;
    int nret;
    if (!rst_n_in) begin
      model_reset();
    end else begin
      need = $countones(alloc_request_in);
      nret = $countones(retire_valid_in);
      if (alloc_valid_in && !flush_in && m_free.size() >= need)
        for (int k = 0; k < need; k++) m_spec.push_back(m_free.pop_front());
      for (int k = 0; k < nret; k++)
        if (m_spec.size() > 0) void'(m_spec.pop_front());
      if (flush_in)
        while (m_spec.size() > 0) m_free.push_front(m_spec.pop_back());
      for (int i = 0; i < W; i++)
        if (free_valid_in[i]) m_free.push_back(free_preg_in[i]);
    end
  end

  always @(negedge clk_in) begin
    int need;
    int k;
    if (rst_n_in) begin
      need = $countones(alloc_request_in);
      chk("free_count", 32'(free_count_out), 32'(m_free.size()));
      chk("alloc_ready", 32'(alloc_ready_out), 32'(!flush_in && m_free.size() >= need));
      k = 0;
      for (int i = 0; i < W; i++) begin
        if (alloc_request_in[i]) begin
          if (k < m_free.size())
            chk($sformatf("alloc_preg%0d", i), 32'(alloc_preg_out[i]), 32'(m_free[k]));
          k++;
        end
      end
    end
  end

  task automatic set_in(input logic v, input logic [W-1:0] req, input logic [W-1:0] fv,
                        input phys_reg_t f0, input phys_reg_t f1,
                        input logic [W-1:0] rv, input logic fl);
    alloc_valid_in   = v;
    alloc_request_in = req;
    free_valid_in    = fv;
    free_preg_in[0]  = f0;
    free_preg_in[1]  = f1;
    retire_valid_in  = rv;
    flush_in         = fl;
    @(negedge clk_in);
  endtask

  task automatic go();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic alloc2();
    set_in(1'b1, 2'b11, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    alloc_valid_in  = 1'b0;
    free_valid_in   = '0;
    retire_valid_in = '0;
    flush_in        = 1'b0;
    rst_n_in = 1'b0;
    go();
    go();
    rst_n_in = 1'b1;
  endtask

  initial begin
    go();
    go();
    rst_n_in = 1'b1;

    // Reset state and first dual allocation
    alloc2();
    chk("rst_count", 32'(free_count_out), 64);
    chk("rst_ready", 32'(alloc_ready_out), 1);
    chk("t1_preg0", 32'(alloc_preg_out[0]), 64);
    chk("t1_preg1", 32'(alloc_preg_out[1]), 65);
    go();
    idle();
    chk("t1_count", 32'(free_count_out), 62);
    go();

    // Drain to empty
    repeat (31) begin
      alloc2();
      go();
    end
    set_in(1'b1, 2'b01, '0, '0, '0, '0, 1'b0);
    chk("empty_count", 32'(free_count_out), 0);
    chk("empty_ready01", 32'(alloc_ready_out), 0);
    go();
    set_in(1'b1, 2'b00, '0, '0, '0, '0, 1'b0);
    chk("empty_ready00", 32'(alloc_ready_out), 1);
    go();
    idle();
    chk("empty_count_after00", 32'(free_count_out), 0);
    go();

    // Frees are not usable in their arrival cycle
    set_in(1'b0, '0, '0, '0, '0, 2'b11, 1'b0);
    go();
    set_in(1'b0, '0, '0, '0, '0, 2'b11, 1'b0);
    go();
    set_in(1'b0, '0, 2'b01, 7'd100, '0, '0, 1'b0);
    go();
    set_in(1'b1, 2'b11, 2'b11, 7'd3, 7'd7, '0, 1'b0);
    chk("late_free_count", 32'(free_count_out), 1);
    chk("late_free_ready", 32'(alloc_ready_out), 0);
    go();
    alloc2();
    chk("late_free_count_next", 32'(free_count_out), 3);
    chk("late_free_ready_next", 32'(alloc_ready_out), 1);
    chk("late_free_preg0", 32'(alloc_preg_out[0]), 100);
    chk("late_free_preg1", 32'(alloc_preg_out[1]), 3);
    go();
    do_reset();

    // Sparse masks compact onto the oldest free entries
    set_in(1'b1, 2'b10, '0, '0, '0, '0, 1'b0);
    chk("sparse_preg1", 32'(alloc_preg_out[1]), 64);
    go();
    set_in(1'b1, 2'b01, '0, '0, '0, '0, 1'b0);
    chk("sparse_count", 32'(free_count_out), 63);
    chk("sparse_preg0", 32'(alloc_preg_out[0]), 65);
    go();
    do_reset();

    // Flush with a same-cycle retire
    alloc2();
    go();
    alloc2();
    go();
    set_in(1'b0, '0, '0, '0, '0, 2'b01, 1'b0);
    go();
    set_in(1'b1, 2'b11, '0, '0, '0, 2'b01, 1'b1);
    chk("flush_ready", 32'(alloc_ready_out), 0);
    go();
    alloc2();
    chk("flush_count", 32'(free_count_out), 62);
    chk("flush_preg0", 32'(alloc_preg_out[0]), 66);
    chk("flush_preg1", 32'(alloc_preg_out[1]), 67);
    go();
    do_reset();

    // Full wrap of the circular buffer
    repeat (32) begin
      alloc2();
      go();
    end
    for (int j = 0; j < 32; j++) begin
      set_in(1'b0, '0, 2'b11, PREG_W'(100 + 2 * j), PREG_W'(101 + 2 * j), 2'b11, 1'b0);
      go();
    end
    idle();
    chk("wrap_refill_count", 32'(free_count_out), 64);
    go();
    for (int j = 0; j < 32; j++) begin
      alloc2();
      if (j == 0) begin
        chk("wrap_first0", 32'(alloc_preg_out[0]), 100);
        chk("wrap_first1", 32'(alloc_preg_out[1]), 101);
      end
      if (j == 31) begin
        chk("wrap_last0", 32'(alloc_preg_out[0]), 162 % 128);
        chk("wrap_last1", 32'(alloc_preg_out[1]), 163 % 128);
      end
      go();
    end

    // Asynchronous reset mid-stream
    alloc2();
    go();
    rst_n_in = 1'b0;
    #2;
    chk("async_rst_count", 32'(free_count_out), 64);
    go();
    rst_n_in = 1'b1;
    alloc2();
    chk("post_rst_preg0", 32'(alloc_preg_out[0]), 64);
    chk("post_rst_preg1", 32'(alloc_preg_out[1]), 65);
    go();
    idle();
    go();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
